execute_muldiv_unit: RTL and testbench

Parametrised multi-cycle execute sub-unit implementing the RV32M/RV64M multiply and divide group (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the combinational ALU in the execute stage. It accepts one operation at a time over a valid/ready handshake and returns a result with its destination register tag over a second valid/ready handshake. The pipeline stalls on `in_ready` and `out_valid`.

---
 rtl/execute_muldiv_unit.sv | 190 +++++++++++++++++++
 tb/tb_execute_muldiv_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv_unit.sv
// RV32M/RV64M multiply/divide execute sub-unit: iterative shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle combinational product.
module execute_muldiv_unit #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [RD_W-1:0] rd_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [RD_W-1:0] rd_out,
    output logic            busy
);

    localparam int unsigned PROD_W = 2 * XLEN;
    localparam int unsigned CNT_W  = $clog2(XLEN + 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_t;

    state_t              state;
    logic [2:0]          op_q;
    logic [RD_W-1:0]     rd_q;
    logic                sign_q;
    logic [XLEN-1:0]     operand;
    logic [PROD_W-1:0]   acc;
    logic [CNT_W-1:0]    cnt;

    logic                rs1_signed;
    logic                rs2_signed;
    logic                neg1;
    logic                neg2;
    logic [XLEN-1:0]     mag1;
    logic [XLEN-1:0]     mag2;
    logic                res_sign;
    logic                div_by_zero;
    logic                div_overflow;

    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_diff;
    logic [PROD_W-1:0]   step_next;
    logic [PROD_W-1:0]   prod_signed;
    logic [XLEN-1:0]     quot;
    logic [XLEN-1:0]     rem;
    logic [XLEN-1:0]     final_result;

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    // Operand signedness, magnitudes and result sign decided at accept
    always_comb begin
        rs1_signed   = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        rs2_signed   = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        neg1         = rs1_signed & rs1_data[XLEN-1];
        neg2         = rs2_signed & rs2_data[XLEN-1];
        mag1         = neg1 ? XLEN'(-rs1_data) : rs1_data;
        mag2         = neg2 ? XLEN'(-rs2_data) : rs2_data;
        // Remainder follows the dividend; products and quotients follow the operand sign xor
        res_sign     = (op == OP_REM) ? neg1 : (neg1 ^ neg2);
        div_by_zero  = op[2] && (rs2_data == '0);
        div_overflow = ((op == OP_DIV) || (op == OP_REM)) &&
                       (rs1_data == INT_MIN) && (rs2_data == '1);
    end

    // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum  = {1'b0, acc[PROD_W-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        div_diff = acc[PROD_W-1:XLEN-1] - {1'b0, operand};
        if (state == ST_DIV) begin
            step_next = div_diff[XLEN] ? {acc[PROD_W-2:0], 1'b0}
                                       : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            step_next = {mul_sum, acc[XLEN-1:1]};
        end
        prod_signed = sign_q ? PROD_W'(-step_next) : step_next;
        quot        = sign_q ? XLEN'(-step_next[XLEN-1:0]) : step_next[XLEN-1:0];
        rem         = sign_q ? XLEN'(-step_next[PROD_W-1:XLEN]) : step_next[PROD_W-1:XLEN];
        if (state == ST_DIV) begin
            final_result = op_q[1] ? rem : quot;
        end else begin
            final_result = (op_q == OP_MUL) ? prod_signed[XLEN-1:0] : prod_signed[PROD_W-1:XLEN];
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [PROD_W-1:0] fast_prod;
    logic [PROD_W-1:0] fast_prod_signed;
    logic [XLEN-1:0]   fast_result;

    always_comb begin
        fast_prod        = PROD_W'(mag1) * PROD_W'(mag2);
        fast_prod_signed = res_sign ? PROD_W'(-fast_prod) : fast_prod;
        fast_result      = (op == OP_MUL) ? fast_prod_signed[XLEN-1:0]
                                          : fast_prod_signed[PROD_W-1:XLEN];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            rd_out    <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            sign_q    <= 1'b0;
            operand   <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else if (flush) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q   <= op;
                        rd_q   <= rd_in;
                        sign_q <= res_sign;
                        cnt    <= CNT_W'(XLEN);
                        if (div_by_zero) begin
                            result    <= op[1] ? rs1_data : '1;
                            rd_out    <= rd_in;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else if (div_overflow) begin
                            result    <= op[1] ? '0 : rs1_data;
                            rd_out    <= rd_in;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else if (op[2]) begin
                            acc     <= {{XLEN{1'b0}}, mag1};
                            operand <= mag2;
                            state   <= ST_DIV;
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            result    <= fast_result;
                            rd_out    <= rd_in;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
`else
                            acc     <= {{XLEN{1'b0}}, mag2};
                            operand <= mag1;
                            state   <= ST_MUL;
`endif
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    acc <= step_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        result    <= final_result;
                        rd_out    <= rd_q;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Randomized self-checking bench for execute_muldiv_unit against an arithmetic reference model.
module tb_execute_muldiv_unit;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RD_W = 5;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [RD_W-1:0] rd_in;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [RD_W-1:0] rd_out;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    execute_muldiv_unit #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .rd_in     (rd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .rd_out    (rd_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // RISC-V M-extension semantics expressed with plain 64-bit and signed integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, ua, sb, ub, p;
        int ia, ib;
        sa = {{32{a[31]}}, a};
        ua = {32'd0, a};
        sb = {{32{b[31]}}, b};
        ub = {32'd0, b};
        ia = a;
        ib = b;
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == INT_MIN && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == INT_MIN && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2]) begin
            if (b == 0) return 1;
            if (!o[0] && a == INT_MIN && b == 32'hFFFF_FFFF) return 1;
            return XLEN + 1;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 1;
`else
        return XLEN + 1;
`endif
    endfunction

    // Issue one op, wait for the result, optionally stall the consumer, then retire it
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int hold);
        logic [31:0] exp;
        int cyc;
        exp = ref_model(o, a, b);
        cyc = 0;
        while (!in_ready && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        check("in_ready_idle", 64'(in_ready), 64'd1);
        op = o; rs1_data = a; rs2_data = b; rd_in = rd; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        check($sformatf("latency op%0d", o), 64'(cyc), 64'(exp_latency(o, a, b)));
        check($sformatf("result op%0d %h,%h", o, a, b), 64'(result), 64'(exp));
        check("rd_out", 64'(rd_out), 64'(rd));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            op = 3'($urandom);
            @(posedge clk); #1;
            check("hold_result", 64'(result), 64'(exp));
            check("hold_rd_out", 64'(rd_out), 64'(rd));
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_drop", 64'(out_valid), 64'd0);
        check("in_ready_back", 64'(in_ready), 64'd1);
    endtask

    // Start a DIV, then kill it in cycle 10 with flush or reset
    task automatic kill_div(input bit use_rst);
        op = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd7; rd_in = 5'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1;
            check("kill_pre_out_valid", 64'(out_valid), 64'd0);
        end
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0;
        check("kill_in_ready", 64'(in_ready), 64'd1);
        check("kill_busy", 64'(busy), 64'd0);
        check("kill_out_valid", 64'(out_valid), 64'd0);
        if (use_rst) begin
            check("kill_rst_result", 64'(result), 64'd0);
            check("kill_rst_rd_out", 64'(rd_out), 64'd0);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            check("kill_no_out_valid", 64'(out_valid), 64'd0);
        end
        do_op(3'd0, 32'd12345, 32'hFFFF_FFF0, 5'd17, 0);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return INT_MIN;
            3: return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; rs1_data = '0; rs2_data = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_rd_out", 64'(rd_out), 64'd0);

        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 0);
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 0);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 0);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 0);
        do_op(3'd5, 32'hFFFF_FFFF, 32'd2, 5'd10, 0);
        do_op(3'd7, 32'hFFFF_FFFF, 32'd2, 5'd11, 0);
        do_op(3'd4, 32'd5, 32'd0, 5'd12, 0);
        do_op(3'd6, 32'd5, 32'd0, 5'd13, 0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 0);
        do_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 0);

        do_op(3'd4, 32'd100, 32'hFFFF_FFFD, 5'd21, 5);

        kill_div(1'b0);
        kill_div(1'b1);

        for (int n = 0; n < 60; n++) begin
            do_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
                  5'($urandom), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
